data_array_nway: RTL and testbench

- Parametrised N-way successor to the single-way cache data array.
- Holds `num_ways` ways of `2**s_index` lines each, `8*2**s_offset` bits per line.
- Reads all ways of one set in parallel, so the tag/hit logic can select the hit way.
- Writes one way with a byte mask; forwards same-cycle writes to the read data.
- Has a registered read-valid output and a sequential clear engine that zeroes the array after reset or on request.

---
 rtl/data_array_nway_if.sv | 33 +++
 rtl/data_array_nway.sv | 121 ++++++++++++
 tb/tb_data_array_nway.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_array_nway_if.sv
// Bus bundle for data_array_nway: read/write/clear requests and registered
// read results. Parameters must match those of the attached data_array_nway.
interface data_array_nway_if #(
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_offset = 5,
    parameter int unsigned num_ways = 2
);
    localparam int unsigned s_mask = 2**s_offset;
    localparam int unsigned s_line = 8*s_mask;
    localparam int unsigned s_way  = (num_ways > 1) ? $clog2(num_ways) : 1;

    logic                         clear;
    logic                         busy;
    logic                         read;
    logic [s_index-1:0]           rindex;
    logic [num_ways*s_line-1:0]   dataout;
    logic                         dataout_valid;
    logic [s_mask-1:0]            write_en;
    logic [s_way-1:0]             wway;
    logic [s_index-1:0]           windex;
    logic [s_line-1:0]            datain;
    logic                         parity_err;

    modport master (
        output clear, read, rindex, write_en, wway, windex, datain,
        input  busy, dataout, dataout_valid, parity_err
    );

    modport slave (
        input  clear, read, rindex, write_en, wway, windex, datain,
        output busy, dataout, dataout_valid, parity_err
    );
endinterface

// File: rtl/data_array_nway.sv
// N-way cache data array: parallel read of all ways of one set, byte-masked
// single-way write with same-cycle forwarding, registered read data/valid and
// a sequential clear sweep after reset or on request.
// Optional per-byte even parity storage/check: define DATA_ARRAY_PARITY_EN.
module data_array_nway #(
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_offset = 5,
    parameter int unsigned num_ways = 2
) (
    input  logic               clk,
    input  logic               rst,
    data_array_nway_if.slave   bus
);
    localparam int unsigned num_sets = 2**s_index;
    localparam int unsigned s_mask   = 2**s_offset;
    localparam int unsigned s_line   = 8*s_mask;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                      state_q, state_d;
    logic [s_index-1:0]          cnt_q, cnt_d;
    logic [num_ways*s_line-1:0]  dataout_q, dataout_d;
    logic                        valid_q, valid_d;
    logic [s_line-1:0]           mem_q [num_ways][num_sets];
    logic [s_line-1:0]           mem_d [num_ways][num_sets];
`ifdef DATA_ARRAY_PARITY_EN
    logic [s_mask-1:0]           par_q [num_ways][num_sets];
    logic [s_mask-1:0]           par_d [num_ways][num_sets];
    logic                        perr_q, perr_d;
`endif

    // Next-state: clear sweep, clear request, then write-before-read so the
    // read port sees this cycle's write (forwarding falls out of mem_d).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dataout_d = dataout_q;
        valid_d   = 1'b0;
        mem_d     = mem_q;
`ifdef DATA_ARRAY_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        if (state_q == ST_CLEAR) begin
            for (int unsigned w = 0; w < num_ways; w++) begin
                mem_d[w][cnt_q] = '0;
`ifdef DATA_ARRAY_PARITY_EN
                par_d[w][cnt_q] = '0;
`endif
            end
            cnt_d = cnt_q + s_index'(1);
            if (cnt_q == s_index'(num_sets - 1)) begin
                state_d = ST_IDLE;
            end
        end else if (bus.clear) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else begin
            if (32'(bus.wway) < num_ways) begin
                for (int unsigned b = 0; b < s_mask; b++) begin
                    if (bus.write_en[b]) begin
                        mem_d[bus.wway][bus.windex][8*b +: 8] = bus.datain[8*b +: 8];
`ifdef DATA_ARRAY_PARITY_EN
                        par_d[bus.wway][bus.windex][b] = ^bus.datain[8*b +: 8];
`endif
                    end
                end
            end
            if (bus.read) begin
                valid_d = 1'b1;
                for (int unsigned w = 0; w < num_ways; w++) begin
                    dataout_d[w*s_line +: s_line] = mem_d[w][bus.rindex];
`ifdef DATA_ARRAY_PARITY_EN
                    for (int unsigned b = 0; b < s_mask; b++) begin
                        perr_d = perr_d |
                                 (par_d[w][bus.rindex][b] ^ (^mem_d[w][bus.rindex][8*b +: 8]));
                    end
`endif
                end
            end
        end
    end

    // Control and output registers; reset restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            dataout_q <= '0;
            valid_q   <= 1'b0;
`ifdef DATA_ARRAY_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            valid_q   <= valid_d;
`ifdef DATA_ARRAY_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // Storage array; contents are zeroed by the sweep, not by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
`ifdef DATA_ARRAY_PARITY_EN
        par_q <= par_d;
`endif
    end

    assign bus.busy          = (state_q == ST_CLEAR);
    assign bus.dataout       = dataout_q;
    assign bus.dataout_valid = valid_q;
`ifdef DATA_ARRAY_PARITY_EN
    assign bus.parity_err    = perr_q;
`else
    assign bus.parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_data_array_nway.sv
// Self-checking bench for data_array_nway: directed vector table, reset/clear
// sequences and randomized traffic against a behavioural array model.
module tb_data_array_nway;
    localparam int unsigned SI = 3;
    localparam int unsigned SO = 5;
    localparam int unsigned NW = 2;
    localparam int unsigned NS = 1 << SI;
    localparam int unsigned SM = 1 << SO;
    localparam int unsigned SL = 8 * SM;
    localparam int unsigned SW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned W  = NW * SL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    data_array_nway_if #(.s_index(SI), .s_offset(SO), .num_ways(NW)) bus ();
    data_array_nway #(.s_index(SI), .s_offset(SO), .num_ways(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: array contents, injected parity faults per byte,
    // expected registered outputs and remaining busy cycles.
    logic [SL-1:0] ref_mem [NW][NS];
    logic [SM-1:0] inj     [NW][NS];
    logic [W-1:0]  ref_do;
    logic          ref_valid;
    logic          ref_perr;
    int            busy_cnt;

    typedef struct {
        logic          rd;
        logic [SI-1:0] ri;
        logic [SM-1:0] we;
        logic [SW-1:0] ww;
        logic [SI-1:0] wi;
        logic [SL-1:0] din;
        logic          exp_valid;
        logic [W-1:0]  exp_do;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                ref_mem[w][s] = '0;
                inj[w][s]     = '0;
            end
    endtask

    task automatic drive(input logic rd, input logic [SI-1:0] ri, input logic [SM-1:0] we,
                         input logic [SW-1:0] ww, input logic [SI-1:0] wi,
                         input logic [SL-1:0] din, input logic clr);
        bus.read = rd; bus.rindex = ri; bus.write_en = we;
        bus.wway = ww; bus.windex = wi; bus.datain = din; bus.clear = clr;
    endtask

    task automatic check_outputs();
        chk("busy", W'(bus.busy), W'(busy_cnt > 0));
        chk("valid", W'(bus.dataout_valid), W'(ref_valid));
        chk("dataout", bus.dataout, ref_do);
        chk("parity_err", W'(bus.parity_err), W'(ref_perr));
    endtask

    // One clock: apply inputs, advance model, compare all outputs.
    task automatic cyc(input logic rd, input logic [SI-1:0] ri, input logic [SM-1:0] we,
                       input logic [SW-1:0] ww, input logic [SI-1:0] wi,
                       input logic [SL-1:0] din, input logic clr);
        drive(rd, ri, we, ww, wi, din, clr);
        @(posedge clk);
        #1;
        ref_valid = 1'b0;
        ref_perr  = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else if (clr) begin
            busy_cnt = NS;
            model_zero();
        end else begin
            if (int'(ww) < NW)
                for (int b = 0; b < SM; b++)
                    if (we[b]) begin
                        ref_mem[ww][wi][8*b +: 8] = din[8*b +: 8];
                        inj[ww][wi][b] = 1'b0;
                    end
            if (rd) begin
                ref_valid = 1'b1;
                for (int w = 0; w < NW; w++) begin
                    ref_do[w*SL +: SL] = ref_mem[w][ri];
                    ref_perr = ref_perr | (|inj[w][ri]);
                end
            end
        end
        check_outputs();
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic rand_cyc(input int clr_div);
        logic [SL-1:0] d;
        logic [SM-1:0] m;
        for (int i = 0; i < SL / 32; i++) d[32*i +: 32] = $urandom;
        case ($urandom % 4)
            0: m = '0;
            1: m = '1;
            default: m = SM'($urandom);
        endcase
        cyc(1'($urandom), SI'($urandom), m, SW'($urandom), SI'($urandom), d,
            (clr_div > 0) && (($urandom % clr_div) == 0));
    endtask

    // Asynchronous reset: outputs must take reset values without a clock edge.
    task automatic do_reset();
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        #2;
        model_zero();
        ref_do = '0; ref_valid = 1'b0; ref_perr = 1'b0; busy_cnt = NS;
        chk("rst_busy", W'(bus.busy), W'(1));
        chk("rst_valid", W'(bus.dataout_valid), '0);
        chk("rst_dataout", bus.dataout, '0);
        chk("rst_perr", W'(bus.parity_err), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts busy cycles, bounded so a stuck sweep still reaches the summary.
    task automatic wait_idle(input int clr_div, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            rand_cyc(clr_div);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [SL-1:0] d;

        vt[0] = '{1'b0, 3'd0, '1, 1'b1, 3'd3, {32{8'hA5}}, 1'b0, '0};
        vt[1] = '{1'b1, 3'd3, '0, 1'b0, 3'd0, '0, 1'b1, {{32{8'hA5}}, 256'h0}};
        vt[2] = '{1'b1, 3'd5, 32'h0000_000F, 1'b0, 3'd5, {{28{8'hFF}}, 32'hDEADBEEF},
                  1'b1, 512'hDEADBEEF};
        vt[3] = '{1'b1, 3'd5, '0, 1'b0, 3'd0, '0, 1'b1, 512'hDEADBEEF};
        vt[4] = '{1'b1, 3'd5, '0, 1'b1, 3'd5, '1, 1'b1, 512'hDEADBEEF};
        vt[5] = '{1'b1, 3'd5, '1, 1'b0, 3'd6, {32{8'h11}}, 1'b1, 512'hDEADBEEF};
        vt[6] = '{1'b1, 3'd6, '0, 1'b0, 3'd0, '0, 1'b1, {256'h0, {32{8'h11}}}};
        vt[7] = '{1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, {256'h0, {32{8'h11}}}};
        vt[8] = '{1'b1, 3'd3, 32'h8000_0001, 1'b1, 3'd3, {8'h3C, 240'h0, 8'hC3},
                  1'b1, {8'h3C, {30{8'hA5}}, 8'hC3, 256'h0}};

        #1;
        do_reset();
        wait_idle(0, n);
        chk("busy_len_reset", W'(n), W'(NS));
        for (int s = 0; s < NS; s++) begin
            cyc(1'b1, SI'(s), '0, '0, '0, '0, 1'b0);
            chk("rd_zero_valid", W'(bus.dataout_valid), W'(1));
            chk("rd_zero_data", bus.dataout, '0);
        end

        for (int i = 0; i < 9; i++) begin
            cyc(vt[i].rd, vt[i].ri, vt[i].we, vt[i].ww, vt[i].wi, vt[i].din, 1'b0);
            chk($sformatf("tbl%0d_valid", i), W'(bus.dataout_valid), W'(vt[i].exp_valid));
            chk($sformatf("tbl%0d_data", i), bus.dataout, vt[i].exp_do);
        end

        // Fill, clear with random traffic (and repeated clears) during the sweep.
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                for (int i = 0; i < SL / 32; i++) d[32*i +: 32] = $urandom | 32'h1;
                cyc(1'b0, '0, '1, SW'(w), SI'(s), d, 1'b0);
            end
        cyc(1'b1, 3'd2, '1, 1'b0, 3'd2, '1, 1'b1);
        wait_idle(3, n);
        chk("busy_len_clear", W'(n), W'(NS));
        for (int s = 0; s < NS; s++) begin
            cyc(1'b1, SI'(s), '0, '0, '0, '0, 1'b0);
            chk("clr_zero_data", bus.dataout, '0);
        end

        for (int i = 0; i < 400; i++) rand_cyc(60);
        wait_idle(0, n);

        // Reset mid-operation, then again at sweep cycle 4.
        cyc(1'b1, 3'd0, '1, 1'b0, 3'd0, '1, 1'b0);
        chk("pre_rst_data_nonzero", W'(bus.dataout != '0), W'(1));
        do_reset();
        repeat (4) idle();
        do_reset();
        wait_idle(0, n);
        chk("busy_len_midsweep", W'(n), W'(NS));

`ifdef DATA_ARRAY_PARITY_EN
        for (int i = 0; i < SL / 32; i++) d[32*i +: 32] = $urandom;
        cyc(1'b0, '0, '1, 1'b1, 3'd2, d, 1'b0);
        dut.par_q[1][2][0] = ~dut.par_q[1][2][0];
        inj[1][2][0] = 1'b1;
        cyc(1'b1, 3'd2, '0, '0, '0, '0, 1'b0);
        chk("perr_set2", W'(bus.parity_err), W'(1));
        cyc(1'b1, 3'd1, '0, '0, '0, '0, 1'b0);
        chk("perr_set1", W'(bus.parity_err), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
